// File: rtl/layer_sched_pkg.sv
// layer_sched_pkg: shared FSM state encoding and frame counter width for layer_sched
package layer_sched_pkg;
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, NEXT, FINISH, ERROR} state_t;
    localparam int FRAME_CNT_W = 16;
endpackage

// File: rtl/layer_sched_stage_pick.sv
// stage_pick: priority encoder returning the lowest enabled stage at or above a lower bound
module stage_pick #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [SW:0]   lo,
    output logic          found,
    output logic [SW-1:0] idx
);
    // scan top-down so the lowest qualifying stage is the last one written
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && i >= int'(lo)) begin
                found = 1'b1;
                idx   = SW'(i);
            end
        end
    end
endmodule

// File: rtl/layer_sched.sv
// layer_sched: sequences enabled layer engines in ascending order, one inference pass per run.
// Optional watchdog (ERROR state, error flag) is built when LAYER_SCHED_WATCHDOG_EN is defined.
module layer_sched
    import layer_sched_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SW             = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   abort,
    input  logic [NUM_STAGES-1:0]  stage_en,
    input  logic [NUM_STAGES-1:0]  stage_done,
    output logic [NUM_STAGES-1:0]  stage_start,
    output logic [SW-1:0]          cur_stage,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    if (NUM_STAGES < 1 || NUM_STAGES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1048575) begin : g_bad_cfg
        $error("layer_sched: parameter out of range");
    end

    state_t                state;
    logic [NUM_STAGES-1:0] mask;
    logic [NUM_STAGES-1:0] pick_mask;
    logic [SW:0]           pick_lo;
    logic                  found;
    logic [SW-1:0]         idx;
    logic                  timeout;

    // IDLE searches the live enable input from stage 0; NEXT searches the latched mask above cur_stage
    assign pick_mask = (state == IDLE) ? stage_en : mask;
    assign pick_lo   = (state == IDLE) ? '0 : {1'b0, cur_stage} + 1'b1;

    stage_pick #(.N(NUM_STAGES), .SW(SW)) u_pick (
        .mask  (pick_mask),
        .lo    (pick_lo),
        .found (found),
        .idx   (idx)
    );

    assign stage_start = (state == LAUNCH) ? NUM_STAGES'(1) << cur_stage : '0;
    assign busy        = state inside {LAUNCH, WAIT_DONE, NEXT, FINISH};
    assign done        = state == FINISH;

`ifdef LAYER_SCHED_WATCHDOG_EN
    logic [19:0] wd;
    assign timeout = wd == 20'(TIMEOUT_CYCLES - 1);
    assign error   = state == ERROR;
    // count consecutive WAIT_DONE cycles; every other state (LAUNCH included) clears the count
    always_ff @(posedge clk)
        wd <= (!rst_n || state != WAIT_DONE) ? '0 : wd + 1'b1;
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    // pass sequencer; abort overrides every other request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask      <= '0;
            cur_stage <= '0;
            frame_cnt <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (run) begin
                    mask  <= stage_en;
                    state <= found ? LAUNCH : FINISH;
                    if (found) cur_stage <= idx;
                end
                LAUNCH:    state <= WAIT_DONE;
                WAIT_DONE: state <= stage_done[cur_stage] ? NEXT : timeout ? ERROR : WAIT_DONE;
                NEXT: begin
                    state <= found ? LAUNCH : FINISH;
                    if (found) cur_stage <= idx;
                end
                FINISH: begin
                    state     <= IDLE;
                    frame_cnt <= frame_cnt + 1'b1;
                end
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_sched.sv
// tb_layer_sched: randomized and directed stimulus checked every cycle against a pass-level model
module tb_layer_sched;
    localparam int N  = 4;
    localparam int TO = 8;

    logic         clk = 1'b0, rst_n = 1'b0, run = 1'b0, abort = 1'b0;
    logic [N-1:0] stage_en = '0, resp_done = '0, extra_done = '0;
    logic [N-1:0] stage_done, stage_start;
    logic [1:0]   cur_stage;
    logic         busy, done, error;
    logic [15:0]  frame_cnt;

    assign stage_done = resp_done | extra_done;
    always #5 clk = ~clk;

    layer_sched #(.NUM_STAGES(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .abort       (abort),
        .stage_en    (stage_en),
        .stage_done  (stage_done),
        .stage_start (stage_start),
        .cur_stage   (cur_stage),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .frame_cnt   (frame_cnt)
    );

    int checks = 0, passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // pass-level model: a pass is the ascending list of enabled stages, walked one launch at a time
    bit          m_act = 0, m_err = 0, m_done = 0, m_gap = 0, m_wait = 0, chk_en = 0, preload = 0;
    int          m_start = -1, m_wd = 0;
    logic [1:0]  m_cur = '0;
    logic [15:0] m_cnt = '0;
    int          q[$];

    task automatic launch_next();
        if (q.size() > 0) begin
            m_start = q.pop_front();
            m_cur   = 2'(m_start);
        end else m_done = 1;
    endtask

    always @(posedge clk) begin
        if (preload) m_cnt = 16'hFFFF;
        if (!rst_n) begin
            {m_act, m_err, m_done, m_gap, m_wait} = '0;
            m_start = -1;
            m_cur   = '0;
            m_cnt   = '0;
            q.delete();
        end else if (abort) begin
            {m_act, m_err, m_done, m_gap, m_wait} = '0;
            m_start = -1;
        end else if (!m_err) begin
            if (m_done) begin
                m_done = 0;
                m_act  = 0;
                m_cnt  = m_cnt + 16'd1;
            end else if (m_start >= 0) begin
                m_start = -1;
                m_wait  = 1;
                m_wd    = 0;
            end else if (m_wait) begin
                if (stage_done[m_cur]) begin
                    m_wait = 0;
                    m_gap  = 1;
                end
`ifdef LAYER_SCHED_WATCHDOG_EN
                else begin
                    m_wd++;
                    if (m_wd == TO) begin
                        m_wait = 0;
                        m_act  = 0;
                        m_err  = 1;
                    end
                end
`endif
            end else if (m_gap) begin
                m_gap = 0;
                launch_next();
            end else if (!m_act && run) begin
                q.delete();
                for (int i = 0; i < N; i++) if (stage_en[i]) q.push_back(i);
                m_act = 1;
                launch_next();
            end
        end
    end

    int seen[$];
    int ndone = 0;

    // compare every output against the model just after each active edge
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("stage_start", 32'(stage_start), (m_start >= 0) ? (32'd1 << m_start) : 32'd0);
            chk("cur_stage", 32'(cur_stage), 32'(m_cur));
            chk("busy", 32'(busy), 32'(m_act));
            chk("done", 32'(done), 32'(m_done));
            chk("error", 32'(error), 32'(m_err));
            chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        end
        if (stage_start != 0) seen.push_back(oh2i(stage_start));
        if (done) ndone++;
    end

    // engine responder: answers each launch after a fixed or random delay
    bit resp_en = 0;
    int resp_dly = 0, r_cnt = 0, r_idx = 0;
    always @(negedge clk) begin
        resp_done = '0;
        if (!resp_en) r_cnt = 0;
        else begin
            if (r_cnt > 0) begin
                r_cnt--;
                if (r_cnt == 0) resp_done[r_idx] = 1'b1;
            end
            if (stage_start != 0) begin
                r_idx = oh2i(stage_start);
                r_cnt = (resp_dly > 0) ? resp_dly : int'($urandom_range(1, 6));
            end
        end
    end

    task automatic wait_done(input int nd0, input int budget);
        for (int i = 0; i < budget && ndone == nd0; i++) @(negedge clk);
        if (ndone == nd0) chk("pass_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_pass(input logic [N-1:0] en, input int budget);
        int nd0;
        nd0 = ndone;
        @(negedge clk);
        run      = 1;
        stage_en = en;
        @(negedge clk);
        run = 0;
        wait_done(nd0, budget);
        @(negedge clk);
    endtask

    initial begin
        int b, nd;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_start", 32'(stage_start), 32'd0);
        chk("reset_cur", 32'(cur_stage), 32'd0);
        chk("reset_frame", 32'(frame_cnt), 32'd0);
        rst_n  = 1;
        chk_en = 1;

        resp_en  = 1;
        resp_dly = 5;
        b  = seen.size();
        nd = ndone;
        run_pass(4'b1111, 200);
        chk("seq_len", 32'(seen.size() - b), 32'd4);
        for (int i = 0; i < 4; i++) chk("seq_order", 32'(seen[b + i]), 32'(i));
        chk("seq_done_cnt", 32'(ndone - nd), 32'd1);
        chk("seq_frame", 32'(frame_cnt), 32'd1);

        resp_dly = 0;
        b = seen.size();
        run_pass(4'b1010, 200);
        chk("sparse_len", 32'(seen.size() - b), 32'd2);
        chk("sparse_first", 32'(seen[b]), 32'd1);
        chk("sparse_second", 32'(seen[b + 1]), 32'd3);
        chk("sparse_frame", 32'(frame_cnt), 32'd2);

        b = seen.size();
        @(negedge clk);
        run      = 1;
        stage_en = 4'b0000;
        @(posedge clk);
        #1;
        chk("empty_done", 32'(done), 32'd1);
        @(negedge clk);
        run = 0;
        @(negedge clk);
        chk("empty_no_start", 32'(seen.size() - b), 32'd0);
        chk("empty_frame", 32'(frame_cnt), 32'd3);

        resp_en = 0;
        b  = seen.size();
        nd = ndone;
        @(negedge clk);
        run      = 1;
        stage_en = 4'b0101;
        @(negedge clk);
        run = 0;
        repeat (2) @(negedge clk);
        extra_done = 4'b0100;
        run        = 1;
        stage_en   = 4'b1111;
        @(negedge clk);
        extra_done = 0;
        run        = 0;
        chk("stray_busy", 32'(busy), 32'd1);
        chk("stray_cur", 32'(cur_stage), 32'd0);
        repeat (3) @(negedge clk);
        chk("stray_no_start", 32'(seen.size() - b), 32'd1);
        extra_done = 4'b0001;
        @(negedge clk);
        extra_done = 0;
        resp_en    = 1;
        wait_done(nd, 100);
        @(negedge clk);
        chk("stray_next", 32'(seen[b + 1]), 32'd2);
        chk("stray_done_cnt", 32'(ndone - nd), 32'd1);
        chk("stray_frame", 32'(frame_cnt), 32'd4);

        resp_en = 0;
        nd = ndone;
        @(negedge clk);
        run      = 1;
        stage_en = 4'b0010;
        @(negedge clk);
        run = 0;
        @(negedge clk);
        extra_done = 4'b0010;
        abort      = 1;
        @(negedge clk);
        extra_done = 0;
        abort      = 0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_frame", 32'(frame_cnt), 32'd4);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(ndone - nd), 32'd0);

`ifdef LAYER_SCHED_WATCHDOG_EN
        @(negedge clk);
        run      = 1;
        stage_en = 4'b0001;
        @(negedge clk);
        run = 0;
        repeat (8) @(negedge clk);
        chk("wd_edge_error", 32'(error), 32'd0);
        @(negedge clk);
        chk("wd_error", 32'(error), 32'd1);
        chk("wd_busy", 32'(busy), 32'd0);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("wd_cleared", 32'(error), 32'd0);
`endif

        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        preload = 1;
        @(negedge clk);
        release dut.frame_cnt;
        preload = 0;
        chk("preload", 32'(frame_cnt), 32'hFFFF);
        run_pass(4'b0000, 20);
        chk("wrap", 32'(frame_cnt), 32'd0);

        resp_en  = 1;
        resp_dly = 0;
        repeat (3000) begin
            @(negedge clk);
            run        = $urandom_range(0, 3) == 0;
            stage_en   = 4'($urandom);
            abort      = $urandom_range(0, 99) == 0;
            rst_n      = $urandom_range(0, 499) != 0;
            extra_done = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
        end
        @(negedge clk);
        run        = 0;
        abort      = 0;
        rst_n      = 1;
        extra_done = 0;
        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
